sim_argmax: RTL

SIM_ARGMAX -- requirements
Module: sim_argmax

---
 rtl/sim_argmax.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sim_argmax.sv
// sim_argmax -- picks the best-matching class for one hypervector query.
//
// A query starts with `start` in IDLE, then NUM_CLASSES similarity scores
// arrive in class order 0..NUM_CLASSES-1. The block keeps a running maximum
// and reports the winning class, its score and whether any other class scored
// the same. The lowest class index wins a tie.
//
// Ports:
//   clk, rst_in             rising-edge clock, synchronous active-high reset
//   start                   begin a new query (only honoured in IDLE)
//   score_valid/score_ready score input handshake (score_in, SCORE_W bits)
//   result_valid/result_ready result output handshake
//   result_class            index of the best-matching class
//   result_score            best score
//   result_tie              another class equalled the best score
//   min_score, result_hit   threshold check (only with SIM_ARGMAX_THRESHOLD_EN)
//   state_dbg               current FSM state, for observation only
//
// Optional feature: define SIM_ARGMAX_THRESHOLD_EN to add min_score/result_hit.
// result_hit is 1 when the best score >= the min_score sampled at start.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. score_ready is 1 only in COLLECT; result_valid is 1 only in RESULT,
// and the result outputs hold steady until the transfer.

module sim_argmax #(
  parameter int LENGTH_VECTOR = 32,
  parameter int NUM_CLASSES   = 8,
  parameter int SCORE_W       = $clog2(LENGTH_VECTOR + 1),
  parameter int CLASS_W       = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_in,
  output logic               score_ready,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CLASS_W-1:0] result_class,
  output logic [SCORE_W-1:0] result_score,
  output logic               result_tie,
`ifdef SIM_ARGMAX_THRESHOLD_EN
  input  logic [SCORE_W-1:0] min_score,
  output logic               result_hit,
`endif
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] RESULT  = 2'd2;

  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [CLASS_W-1:0] idx_q, idx_d;
  logic               tie_q, tie_d;
  logic [CLASS_W-1:0] cnt_q, cnt_d;

`ifdef SIM_ARGMAX_THRESHOLD_EN
  logic [SCORE_W-1:0] min_q, min_d;
`endif

  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    idx_d   = idx_q;
    tie_d   = tie_q;
    cnt_d   = cnt_q;
`ifdef SIM_ARGMAX_THRESHOLD_EN
    min_d   = min_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          best_d  = '0;
          idx_d   = '0;
          tie_d   = 1'b0;
          cnt_d   = '0;
`ifdef SIM_ARGMAX_THRESHOLD_EN
          min_d   = min_score;
`endif
        end
      end
      COLLECT: begin
        if (score_valid) begin
          // Class 0 always loads so a query of all-zero scores still
          // reports class 0 without a stale tie flag.
          if (cnt_q == '0 || score_in > best_q) begin
            best_d = score_in;
            idx_d  = cnt_q;
            tie_d  = 1'b0;
          end else if (score_in == best_q) begin
            tie_d = 1'b1;
          end
          // The counter stops at the last class instead of wrapping.
          if (cnt_q == LAST_CLASS) begin
            state_d = RESULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESULT: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= IDLE;
      best_q  <= '0;
      idx_q   <= '0;
      tie_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef SIM_ARGMAX_THRESHOLD_EN
      min_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      tie_q   <= tie_d;
      cnt_q   <= cnt_d;
`ifdef SIM_ARGMAX_THRESHOLD_EN
      min_q   <= min_d;
`endif
    end
  end

  assign score_ready  = (state_q == COLLECT);
  assign result_valid = (state_q == RESULT);
  assign result_class = idx_q;
  assign result_score = best_q;
  assign result_tie   = tie_q;
  assign state_dbg    = state_q;

`ifdef SIM_ARGMAX_THRESHOLD_EN
  // Qualified by RESULT so the flag reads 0 out of reset and between queries.
  assign result_hit = (state_q == RESULT) && (best_q >= min_q);
`endif

endmodule
